// File: rtl/prio_pkg.sv
// Shared types and helpers for the priority arbiter.
package prio_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } arb_mode_e;

  localparam int MAX_N = 64;

  // Wide one-hot; callers slice the low N bits.
  function automatic logic [MAX_N-1:0] idx_to_oh(input int unsigned idx);
    return {{(MAX_N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational lowest-set-bit encoder.
module prio_enc_core #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-input arbiter, fixed-priority or round-robin, with a
// valid/ready grant handshake.
module prio_arbiter
  import prio_pkg::*;
#(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  arb_mode_e       mode,
  input  logic            gnt_ready,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_idx,
  output logic [N-1:0]    gnt_oh
);

  logic [IW-1:0]    ptr;
  logic [N-1:0]     req_masked;
  logic [IW-1:0]    m_idx;
  logic [IW-1:0]    u_idx;
  logic             m_found;
  logic             u_found;
  logic [IW-1:0]    win_idx;
  logic [MAX_N-1:0] win_oh_wide;
  logic             load;
  logic             accept;

  assign load   = !gnt_valid || gnt_ready;
  assign accept = gnt_valid && gnt_ready;

  always_comb begin
    req_masked = '0;
    for (int i = 0; i < N; i++) begin
      req_masked[i] = req[i] && (i >= int'(ptr));
    end
  end

  prio_enc_core #(.N(N)) u_enc_masked (
    .req   (req_masked),
    .idx   (m_idx),
    .found (m_found)
  );

  prio_enc_core #(.N(N)) u_enc_full (
    .req   (req),
    .idx   (u_idx),
    .found (u_found)
  );

  // Nothing at or above ptr falls back to the lowest requester (wrap).
  always_comb begin
    win_idx = u_idx;
    if (mode == MODE_RR && m_found) begin
      win_idx = m_idx;
    end
  end

  assign win_oh_wide = idx_to_oh(int'(win_idx));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      gnt_oh    <= '0;
    end else if (load) begin
      gnt_valid <= u_found;
      gnt_idx   <= u_found ? win_idx : '0;
      gnt_oh    <= u_found ? win_oh_wide[N-1:0] : '0;
    end
  end

  // Advances off the grant being retired, not the one being issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (accept && mode == MODE_RR) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule
